modmul_sequencer: RTL

- Sequential modular multiplier: computes result = (a · b) mod M, with M = 2^N − k.
- Time-shares one instance of the team's combinational parallel-prefix modulo adder, which computes (x + y) mod (2^N − k).
- Uses MSB-first interleaved double-and-add over the bits of b.
- Sits between an operand-issuing controller and downstream consumers; one multiplication in flight at a time, with a start/done handshake.

---
 rtl/modmul_sequencer.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/modmul_sequencer.sv
// Sequential modular multiplier: (a * b) mod (2^N - k) by MSB-first double-and-add,
// time-sharing one parallel-prefix modulo adder across the DBL and ADD steps.
module modmul_sequencer #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [N-1:0] k,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] result
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned AW = N + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_DBL,
        S_ADD,
        S_DONE
    } state_t;

    state_t         state, state_d;
    logic [N-1:0]   a_reg, a_reg_d;
    logic [N-1:0]   b_reg, b_reg_d;
    logic [N-1:0]   k_reg, k_reg_d;
    logic [N-1:0]   acc, acc_d;
    logic [IW-1:0]  idx, idx_d;
    logic [N-1:0]   result_d;
    logic           err_d;
    logic           ready_d;
    logic           busy_d;
    logic           done_d;

    logic [N-1:0]   add_y_c;
    logic [N-1:0]   add_sum_c;
    logic [N:0]     mod_full_c;
    logic           a_oob_c;
    logic           b_oob_c;
    logic           bad_operands_c;

    // Kogge-Stone carry tree; operands are zero-extended so the top bit never carries out.
    function automatic logic [AW-1:0] prefix_add(input logic [AW-1:0] x, input logic [AW-1:0] y);
        logic [AW-2:0] g;
        logic [AW-2:0] p;
        logic [AW-1:0] h;
        g = x[AW-2:0] & y[AW-2:0];
        p = x[AW-2:0] ^ y[AW-2:0];
        h = x ^ y;
        for (int unsigned d = 1; d < AW - 1; d = d * 2) begin
            for (int unsigned i = AW - 2; i >= d; i--) begin
                g[i] = g[i] | (p[i] & g[i-d]);
                p[i] = p[i] & p[i-d];
            end
        end
        return h ^ {g, 1'b0};
    endfunction

    // (x + y) mod (2^N - k) for x, y < M: subtract M exactly when x + y + k reaches 2^N.
    function automatic logic [N-1:0] mod_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                             input logic [N-1:0] kk);
        logic [AW-1:0] s;
        logic [AW-1:0] t;
        s = prefix_add({2'b00, x}, {2'b00, y});
        t = prefix_add(s, {2'b00, kk});
        return (t[AW-1:N] != 2'b00) ? t[N-1:0] : s[N-1:0];
    endfunction

    // Single shared adder: DBL feeds (acc, acc), ADD feeds (acc, a_reg or 0).
    always_comb begin
        add_y_c = acc;
        if (state == S_ADD) begin
            add_y_c = b_reg[idx] ? a_reg : '0;
        end
    end

    assign add_sum_c = mod_add(acc, add_y_c, k_reg);

    assign mod_full_c     = {1'b1, {N{1'b0}}} - {1'b0, k_reg};
    assign a_oob_c        = {1'b0, a_reg} >= mod_full_c;
    assign b_oob_c        = {1'b0, b_reg} >= mod_full_c;
    assign bad_operands_c = (k_reg == {N{1'b1}}) ||
                            ((k_reg != '0) && (a_oob_c || b_oob_c));

    always_comb begin
        state_d  = state;
        a_reg_d  = a_reg;
        b_reg_d  = b_reg;
        k_reg_d  = k_reg;
        acc_d    = acc;
        idx_d    = idx;
        result_d = result;
        err_d    = err;

        case (state)
            S_IDLE: begin
                if (start) begin
                    a_reg_d  = a;
                    b_reg_d  = b;
                    k_reg_d  = k;
                    acc_d    = '0;
                    idx_d    = IW'(N - 1);
                    result_d = '0;
                    err_d    = 1'b0;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (bad_operands_c) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    state_d = S_DBL;
                end
            end
            S_DBL: begin
                acc_d   = add_sum_c;
                state_d = S_ADD;
            end
            S_ADD: begin
                acc_d = add_sum_c;
                if (idx == '0) begin
                    result_d = add_sum_c;
                    state_d  = S_DONE;
                end else begin
                    idx_d   = idx - 1'b1;
                    state_d = S_DBL;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d == S_CHECK) || (state_d == S_DBL) || (state_d == S_ADD);
        done_d  = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            k_reg  <= '0;
            acc    <= '0;
            idx    <= '0;
            result <= '0;
            err    <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            a_reg  <= a_reg_d;
            b_reg  <= b_reg_d;
            k_reg  <= k_reg_d;
            acc    <= acc_d;
            idx    <= idx_d;
            result <= result_d;
            err    <= err_d;
            ready  <= ready_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

endmodule
